// File: rtl/decode_pipe_ctrl.sv
// decode_pipe_ctrl: ID-stage decoder and one-entry ID/EX register with a
// valid/ready handshake. The block inserts a bubble on a load-use hazard, drops
// the ID/EX contents on a branch flush, and drains and then halts on a syscall.
// Optional feature: define DECODE_ILLEGAL_EN to flag undefined encodings on
// illegal_o and halt the core as soon as one is accepted.
module decode_pipe_ctrl #(
    parameter int         DRAIN_CYCLES   = 3,
    parameter int         LOAD_USE_STALL = 1,
    parameter logic [4:0] RA_REG         = 5'd31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] id_instr,
    input  logic        id_valid,
    output logic        id_ready,
    input  logic        ex_ready,
    input  logic        flush_i,
    input  logic        resume_i,
    output logic        ex_valid,
    output logic [19:0] ex_ctrl,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_dst,
    output logic        halt_o,
    output logic        illegal_o
);

    typedef struct packed {
        logic [1:0] rw;
        logic       we;
        logic [1:0] w;
        logic [1:0] y;
        logic [3:0] alu;
        logic       pc_j;
        logic       pc_jr;
        logic       blez;
        logic       beq;
        logic       bne;
        logic       sto;
        logic       load;
        logic       half;
        logic       sys;
    } ctrl_t;

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALT} state_t;

    // A counter of at least one bit keeps DRAIN_CYCLES=0 legal.
    localparam int CNT_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(DRAIN_CYCLES);

    logic [5:0] op, funct;
    logic [4:0] rs, rt, rd;
    ctrl_t      dc;
    logic [4:0] d_dst;
    logic       d_legal, reads_rs, reads_rt;
    logic       hazard, accept;
    state_t     state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic       unused_shamt;

    assign op    = id_instr[31:26];
    assign rs    = id_instr[25:21];
    assign rt    = id_instr[20:16];
    assign rd    = id_instr[15:11];
    assign funct = id_instr[5:0];
    assign unused_shamt = ^id_instr[10:6];

    // Decode the ID instruction into a control bundle, destination and read-port usage.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
        dc       = '0;
        d_dst    = 5'd0;
        d_legal  = 1'b1;
        reads_rs = 1'b1;
        reads_rt = 1'b0;
        case (op)
            6'b000000: begin
                reads_rt = 1'b1;
                case (funct)
                    6'b100000, 6'b100001: dc.alu = 4'b0101;
                    6'b100010:            dc.alu = 4'b0110;
                    6'b100100:            dc.alu = 4'b0111;
                    6'b100101:            dc.alu = 4'b1000;
                    6'b100111:            dc.alu = 4'b1010;
                    6'b101010, 6'b101011: dc.alu = 4'b1011;
                    6'b000110:            dc.alu = 4'b0010;
                    6'b000111:            dc.alu = 4'b0001;
                    6'b000000: begin dc.alu = 4'b0000; dc.y = 2'b01; reads_rs = 1'b0; end
                    6'b000011: begin dc.alu = 4'b0010; dc.y = 2'b01; reads_rs = 1'b0; end
                    6'b000010: begin dc.alu = 4'b0100; dc.y = 2'b01; reads_rs = 1'b0; end
                    6'b001000: dc.pc_jr = 1'b1;
                    6'b001100: begin dc.sys = 1'b1; reads_rs = 1'b0; end
                    default:   d_legal = 1'b0;
                endcase
                if (d_legal && !dc.pc_jr && !dc.sys) begin
                    dc.we = 1'b1;
                    d_dst = rd;
                end
            end
            6'b001000, 6'b001001, 6'b001100, 6'b001101, 6'b001010: begin
                dc.we = 1'b1;
                dc.rw = 2'b11;
                dc.y  = 2'b11;
                d_dst = rt;
                case (op)
                    6'b001100: dc.alu = 4'b0111;
                    6'b001101: dc.alu = 4'b1000;
                    6'b001010: dc.alu = 4'b1011;
                    default:   dc.alu = 4'b0101;
                endcase
            end
            6'b100001, 6'b100011: begin
                dc.load = 1'b1;
                dc.half = (op == 6'b100001);
                dc.alu  = 4'b0101;
                dc.we   = 1'b1;
                dc.rw   = 2'b11;
                dc.w    = 2'b11;
                dc.y    = 2'b11;
                d_dst   = rt;
            end
            6'b101011: begin
                dc.sto   = 1'b1;
                dc.alu   = 4'b0101;
                dc.y     = 2'b11;
                reads_rt = 1'b1;
            end
            6'b000010: begin
                dc.pc_j  = 1'b1;
                reads_rs = 1'b0;
            end
            6'b000011: begin
                dc.pc_j  = 1'b1;
                dc.we    = 1'b1;
                dc.rw    = 2'b01;
                dc.w     = 2'b01;
                d_dst    = RA_REG;
                reads_rs = 1'b0;
            end
            6'b000100, 6'b000101, 6'b000110: begin
                dc.beq   = (op == 6'b000100);
                dc.bne   = (op == 6'b000101);
                dc.blez  = (op == 6'b000110);
                dc.alu   = 4'b0110;
                reads_rt = (op != 6'b000110);
            end
            default: d_legal = 1'b0;
        endcase
        if (!d_legal) begin
            dc    = '0;
            d_dst = 5'd0;
        end
    end

    // A load in EX whose destination feeds the ID instruction needs one bubble when there is no forwarding path.
    assign hazard = (LOAD_USE_STALL != 0) && ex_valid && ex_ctrl[2] && (ex_dst != 5'd0) &&
                    ((reads_rs && (rs == ex_dst)) || (reads_rt && (rt == ex_dst)));

    // During a flush the ID instruction is consumed and dropped, whatever the stage state.
    assign id_ready = flush_i || ((state == ST_RUN) && !hazard && (!ex_valid || ex_ready));
    assign accept   = id_valid && id_ready && !flush_i;

    // ID/EX register: flush, then bubble, then load, then drain on consume; otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state is updated with <= only, so every register samples pre-edge values.
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
            ex_rs    <= 5'd0;
            ex_rt    <= 5'd0;
            ex_dst   <= 5'd0;
        end else if (flush_i) begin
            ex_valid <= 1'b0;
        end else if (hazard && ex_ready) begin
            ex_valid <= 1'b0;
        end else if (accept) begin
            ex_valid <= 1'b1;
            ex_ctrl  <= dc;
            ex_rs    <= rs;
            ex_rt    <= rt;
            ex_dst   <= d_dst;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

    // Syscall/illegal halt FSM: next-state and drain count.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_RUN: begin
                if (accept && dc.sys) begin
                    if (DRAIN_CYCLES == 0) begin
                        state_next = ST_HALT;
                    end else begin
                        state_next = ST_DRAIN;
                        cnt_next   = DRAIN_INIT;
                    end
                end
`ifdef DECODE_ILLEGAL_EN
                else if (accept && !d_legal) begin
                    state_next = ST_HALT;
                end
`endif
            end
            ST_DRAIN: begin
                if (cnt == '0) begin
                    state_next = ST_HALT;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            ST_HALT: begin
                if (resume_i) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    // FSM state and drain counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    assign halt_o = (state == ST_HALT);

`ifdef DECODE_ILLEGAL_EN
    // illegal_o travels with the ID/EX entry it describes and is refreshed on every load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_o <= 1'b0;
        end else if (accept) begin
            illegal_o <= !d_legal;
        end
    end
`else
    assign illegal_o = 1'b0;
`endif

endmodule
